// File: rtl/rle_image_decompressor_if.sv
// Bus bundle for the RLE image decompressor: job control, the compressed
// word stream with its ready/valid handshake, and the RAM write port.
interface rle_image_decompressor_if #(
  parameter int ADDR_W = 16
);
  logic              en;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       word_in;
  logic              word_valid;
  logic              word_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_data;
  logic              done;
  logic              overflow;

  // Producer side: starts jobs and supplies compressed words.
  modport master (
    output en, base_addr, word_in, word_valid,
    input  word_ready, ram_we, ram_addr, ram_data, done, overflow
  );

  // Decompressor side.
  modport slave (
    input  en, base_addr, word_in, word_valid,
    output word_ready, ram_we, ram_addr, ram_data, done, overflow
  );
endinterface

// File: rtl/rle_image_decompressor.sv
// RLE image decompressor: expands {value, run} words into a binary image,
// packs 16 pixels per RAM word (first pixel in bit 15) and writes them to
// consecutive addresses starting at the latched base address.
module rle_image_decompressor #(
  parameter int IMG_PIXELS = 784,
  parameter int ADDR_W     = 16
) (
  input logic clk,
  input logic RST,
  rle_image_decompressor_if.slave bus
);
  localparam int PIX_W = $clog2(IMG_PIXELS + 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_PIXELS - 1);

  typedef enum logic [2:0] {IDLE, WAIT_WORD, EXPAND, FLUSH, DONE} state_t;

  state_t            stateReg, stateNext;
  logic [ADDR_W-1:0] wordAddrReg, ramAddrReg;
  logic [15:0]       shiftReg, ramDataReg;
  logic [3:0]        bitCountReg;
  logic [PIX_W-1:0]  pixCountReg;
  logic [14:0]       runReg;
  logic              pixValReg, ramWeReg, overflowReg;

  logic        startJob, acceptWord, shiftPixel, setOverflow, flushWrite, leaveJob;
  logic        wordReady, doneFlag;
  logic [15:0] shiftNext;
  logic [4:0]  padShift;

  // Next pixel group contents and the left shift that moves a partial group
  // up against bit 15 with zeros in the unused LSBs.
  assign shiftNext = {shiftReg[14:0], pixValReg};
  assign padShift  = 5'd16 - {1'b0, bitCountReg};

  // State register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) stateReg <= IDLE;
    else      stateReg <= stateNext;
  end

  // Next-state logic and control strobes; dropping en aborts any active job.
  always_comb begin
    stateNext   = stateReg;
    startJob    = 1'b0;
    acceptWord  = 1'b0;
    shiftPixel  = 1'b0;
    setOverflow = 1'b0;
    flushWrite  = 1'b0;
    leaveJob    = 1'b0;
    wordReady   = 1'b0;
    doneFlag    = 1'b0;
    case (stateReg)
      IDLE: begin
        if (bus.en) begin
          startJob  = 1'b1;
          stateNext = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (!bus.en) begin
          leaveJob  = 1'b1;
          stateNext = IDLE;
        end else begin
          wordReady = 1'b1;
          if (bus.word_valid) begin
            acceptWord = 1'b1;
            // A zero-length run carries no pixels, so keep waiting.
            if (bus.word_in[14:0] != 15'd0) stateNext = EXPAND;
          end
        end
      end
      EXPAND: begin
        if (!bus.en) begin
          leaveJob  = 1'b1;
          stateNext = IDLE;
        end else begin
          shiftPixel = 1'b1;
          if (pixCountReg == LAST_PIX) begin
            // Image full: any run left over is discarded and flagged.
            stateNext   = FLUSH;
            setOverflow = (runReg != 15'd1);
          end else if (runReg == 15'd1) begin
            stateNext = WAIT_WORD;
          end
        end
      end
      FLUSH: begin
        if (!bus.en) begin
          leaveJob  = 1'b1;
          stateNext = IDLE;
        end else begin
          flushWrite = (bitCountReg != 4'd0);
          stateNext  = DONE;
        end
      end
      DONE: begin
        doneFlag = 1'b1;
        if (!bus.en) begin
          leaveJob  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: run/pixel counters, pixel packing and the registered RAM write port.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wordAddrReg <= '0;
      ramAddrReg  <= '0;
      shiftReg    <= '0;
      ramDataReg  <= '0;
      bitCountReg <= '0;
      pixCountReg <= '0;
      runReg      <= '0;
      pixValReg   <= 1'b0;
      ramWeReg    <= 1'b0;
      overflowReg <= 1'b0;
    end else begin
      ramWeReg <= 1'b0;
      if (startJob) begin
        wordAddrReg <= bus.base_addr;
        pixCountReg <= '0;
        bitCountReg <= '0;
        shiftReg    <= '0;
        overflowReg <= 1'b0;
      end
      if (leaveJob) overflowReg <= 1'b0;
      if (acceptWord) begin
        pixValReg <= bus.word_in[15];
        runReg    <= bus.word_in[14:0];
      end
      if (shiftPixel) begin
        shiftReg    <= shiftNext;
        runReg      <= runReg - 15'd1;
        pixCountReg <= pixCountReg + PIX_W'(1);
        bitCountReg <= bitCountReg + 4'd1;
        // Sixteenth bit of the group: hand the full word to the RAM port.
        if (bitCountReg == 4'd15) begin
          ramWeReg    <= 1'b1;
          ramDataReg  <= shiftNext;
          ramAddrReg  <= wordAddrReg;
          wordAddrReg <= wordAddrReg + ADDR_W'(1);
        end
      end
      if (setOverflow) overflowReg <= 1'b1;
      if (flushWrite) begin
        ramWeReg    <= 1'b1;
        ramDataReg  <= shiftReg << padShift;
        ramAddrReg  <= wordAddrReg;
        wordAddrReg <= wordAddrReg + ADDR_W'(1);
      end
    end
  end

  assign bus.word_ready = wordReady;
  assign bus.done       = doneFlag;
  assign bus.overflow   = overflowReg;
  assign bus.ram_we     = ramWeReg;
  assign bus.ram_addr   = ramAddrReg;
  assign bus.ram_data   = ramDataReg;
endmodule
